// File: rtl/config_stream_loader.sv
// config_stream_loader
// Upstream configuration master for the PE tile array. Assembles 8-byte
// records {config_addr[31:0], config_data[31:0]} (each word MSB first) from a
// byte stream and drives each record onto the shared config bus for exactly
// one clock. At all other times the bus shows IDLE_ADDR with zero data.
// A record whose address equals END_ADDR ends the load and is never issued.
//
// Handshake: a byte moves on a rising edge where in_valid && in_ready.
// in_ready is high only while collecting. The upstream holds in_valid and
// in_data stable until the byte is taken. restart takes priority over
// acceptance, so a byte offered during a restart edge is dropped.
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous reset, active low
//   restart        synchronous abort of the current load, starts a new one
//   in_data[7:0]   bitstream byte
//   in_valid       in_data is valid
//   in_ready       loader accepts a byte this cycle
//   config_addr    {type[31:16], tile_id[15:0]} to all tiles (registered)
//   config_data    configuration payload to all tiles (registered)
//   busy           record partially assembled, issuing, or in gap
//   done           terminator received (sticky until restart/reset)
//   record_count   records issued since reset/restart, saturating
//   fsm_state      current FSM state, for debug visibility
module config_stream_loader #(
  parameter logic [31:0] IDLE_ADDR  = 32'h0000_0000,
  parameter logic [31:0] END_ADDR   = 32'hFFFF_FFFF,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        restart,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] config_addr,
  output logic [31:0] config_data,
  output logic        busy,
  output logic        done,
  output logic [15:0] record_count,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    ISSUE   = 2'd1,
    GAP     = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Gap counter preload; only used when GAP_CYCLES > 0.
  localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);

  state_t      state, state_next;
  logic [2:0]  byte_idx;
  logic [31:0] addr_sr;
  logic [23:0] data_sr;
  logic [3:0]  gap_cnt;
  logic        accept;
  logic        last_byte;
  logic        is_end;

  assign accept    = in_valid && (state == COLLECT);
  assign last_byte = accept && (byte_idx == 3'd7);
  // By byte 7 the address shift register already holds all four address bytes.
  assign is_end    = (addr_sr == END_ADDR);

  assign in_ready  = (state == COLLECT);
  assign busy      = (state == ISSUE) || (state == GAP) ||
                     ((state == COLLECT) && (byte_idx != 3'd0));
  assign fsm_state = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= COLLECT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (restart) begin
      state_next = COLLECT;
    end else begin
      case (state)
        COLLECT: if (last_byte) state_next = is_end ? DONE : ISSUE;
        ISSUE:   state_next = (GAP_CYCLES > 0) ? GAP : COLLECT;
        GAP:     if (gap_cnt == 4'd0) state_next = COLLECT;
        DONE:    state_next = DONE;
        default: state_next = COLLECT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_idx     <= 3'd0;
      addr_sr      <= 32'd0;
      data_sr      <= 24'd0;
      gap_cnt      <= 4'd0;
      config_addr  <= IDLE_ADDR;
      config_data  <= 32'd0;
      done         <= 1'b0;
      record_count <= 16'd0;
    end else if (restart) begin
      byte_idx     <= 3'd0;
      gap_cnt      <= 4'd0;
      config_addr  <= IDLE_ADDR;
      config_data  <= 32'd0;
      done         <= 1'b0;
      record_count <= 16'd0;
    end else begin
      // The bus falls back to idle every cycle unless a record completes on
      // this edge, which makes each write last exactly one clock.
      config_addr <= IDLE_ADDR;
      config_data <= 32'd0;
      if (accept) begin
        byte_idx <= byte_idx + 3'd1;
        if (!byte_idx[2]) begin
          addr_sr <= {addr_sr[23:0], in_data};
        end else begin
          data_sr <= {data_sr[15:0], in_data};
        end
        if (last_byte) begin
          if (is_end) begin
            done <= 1'b1;
          end else begin
            config_addr <= addr_sr;
            config_data <= {data_sr, in_data};
            if (record_count != 16'hFFFF) begin
              record_count <= record_count + 16'd1;
            end
          end
        end
      end
      if (state == ISSUE) begin
        gap_cnt <= GAP_LOAD;
      end else if ((state == GAP) && (gap_cnt != 4'd0)) begin
        gap_cnt <= gap_cnt - 4'd1;
      end
    end
  end

endmodule
